// File: rtl/uart_rx_frame_pkg.sv
// Shared types and constants for the UART receive slice.
// Optional even-parity support is selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        RX_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: serial line in, recovered byte and status out.
// The parity_err member exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_frame_if;
  import uart_rx_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 done;
  logic                 frame_err;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport master (input rx, output rx_data, output done, output frame_err, output parity_err);
  modport slave  (output rx, input rx_data, input done, input frame_err, input parity_err);
`else
  modport master (input rx, output rx_data, output done, output frame_err);
  modport slave  (output rx, input rx_data, input done, input frame_err);
`endif

endinterface

// File: rtl/uart_rx_frame_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a
// parameterised reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 8N1 frames, or 8E1 when UART_RX_PARITY_EN is
// defined. done is a level flag held from the stop sample until the next start.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_frame_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t            state, state_next;
  logic                 rx_s;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] rx_data;
  logic                 done;
  logic                 frame_err;
  logic                 armed;
  logic                 start_det, shift_en, stop_en;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 parity_err_next;
  logic                 parity_err;
`endif

  sync_2ff #(.WIDTH(1), .RST_VAL(RX_IDLE)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s && armed) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: begin
        if (clk_cnt == HALF_M1) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (clk_cnt == FULL_M1) begin
          shift_en = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL_M1) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL_M1) begin
          stop_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // armed blocks a new start after a low stop bit until the line is seen high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE) clk_cnt <= '0;
      else                                     clk_cnt <= clk_cnt + 1'b1;
      if (shift_en) begin
        shift   <= {rx_s, shift[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (start_det) done <= 1'b0;
      if (stop_en) begin
        rx_data   <= shift;
        frame_err <= ~rx_s;
        done      <= 1'b1;
        armed     <= rx_s;
      end else if (rx_s) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err_next <= 1'b0;
      parity_err      <= 1'b0;
    end else begin
      if (par_en)  parity_err_next <= rx_s ^ (^shift);
      if (stop_en) parity_err      <= parity_err_next;
    end
  end

  assign bus.parity_err = parity_err;
`endif

  assign bus.rx_data   = rx_data;
  assign bus.done      = done;
  assign bus.frame_err = frame_err;

endmodule
